// File: rtl/sop_eval_pkg.sv
// Shared types and width helpers for the sum-of-products evaluator.
package sop_eval_pkg;

  localparam int N_IN_DEF    = 4;
  localparam int N_TERMS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Term-index width; a single term still needs a 1-bit index port.
  function automatic int idx_w(input int n_terms);
    return (n_terms > 1) ? $clog2(n_terms) : 1;
  endfunction

  // Truth-table width: one bit per input combination.
  function automatic int tt_w(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  localparam int IDX_W = idx_w(N_TERMS_DEF);
  localparam int TT_W  = tt_w(N_IN_DEF);

endpackage

// File: rtl/sop_eval_term_match.sv
// One product term: hits when enabled and every cared-for input bit
// equals the programmed literal value.
module sop_term_match #(
  parameter int N_IN = 4
) (
  input  logic [N_IN-1:0] mask,
  input  logic [N_IN-1:0] val,
  input  logic            en,
  input  logic [N_IN-1:0] inp,
  output logic            hit
);

  assign hit = en && (((inp ^ val) & mask) == {N_IN{1'b0}});

endmodule

// File: rtl/sop_eval.sv
// Programmable sum-of-products evaluator: term table written through a
// config handshake, two-stage evaluation pipeline with backpressure, and a
// scan mode that sweeps every input vector into a truth-table register.
module sop_eval
  import sop_eval_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_TERMS = N_TERMS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [idx_w(N_TERMS)-1:0]  cfg_idx,
  input  logic [N_IN-1:0]            cfg_mask,
  input  logic [N_IN-1:0]            cfg_val,
  input  logic                       cfg_en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            inp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out,
  output logic [N_TERMS-1:0]         out_hit,
  input  logic                       scan_start,
  output logic                       scan_busy,
  output logic                       scan_done,
  output logic [tt_w(N_IN)-1:0]      tt
);

  localparam int TW = tt_w(N_IN);
  localparam int CW = N_IN + 1;
  localparam logic [CW-1:0] LAST_VEC = CW'(TW - 1);

  state_t              state_r, state_s;
  logic                live_r;
  logic                scan_done_r, done_s;
  logic [CW-1:0]       cnt_r;
  logic [N_IN-1:0]     mask_r [N_TERMS];
  logic [N_IN-1:0]     val_r  [N_TERMS];
  logic [N_TERMS-1:0]  en_r;
  logic [TW-1:0]       tt_r;

  logic                s1_valid_r, s1_scan_r;
  logic [N_TERMS-1:0]  s1_hit_r;
  logic [N_IN-1:0]     s1_vec_r;
  logic                s2_valid_r, s2_scan_r, s2_out_r;
  logic [N_TERMS-1:0]  s2_hit_r;
  logic [N_IN-1:0]     s2_vec_r;

  logic                pipe_empty_s, s2_xfer_s, s2_can_s, s1_adv_s, s1_can_s;
  logic                cfg_ready_s, cfg_fire_s, scan_go_s;
  logic                in_ready_s, in_fire_s, scan_inj_s, s1_load_s;
  logic [N_IN-1:0]     eval_vec_s;
  logic [N_TERMS-1:0]  hit_s;

  // Scan entries never wait on the consumer, so they always leave S2.
  assign pipe_empty_s = !s1_valid_r && !s2_valid_r;
  assign s2_xfer_s    = s2_valid_r && (s2_scan_r || out_ready);
  assign s2_can_s     = !s2_valid_r || s2_xfer_s;
  assign s1_adv_s     = s1_valid_r && s2_can_s;
  assign s1_can_s     = !s1_valid_r || s1_adv_s;

  // live_r keeps both readies low until the first edge after reset.
  assign cfg_ready_s  = live_r && (state_r == ST_IDLE) && pipe_empty_s;
  assign cfg_fire_s   = cfg_valid && cfg_ready_s;
  assign scan_go_s    = scan_start && cfg_ready_s;
  // A scan launch also blocks evaluations so no external result mixes in.
  assign in_ready_s   = live_r && (state_r == ST_IDLE) && s1_can_s
                        && !cfg_fire_s && !scan_go_s;
  assign in_fire_s    = in_valid && in_ready_s;
  assign scan_inj_s   = (state_r == ST_SCAN) && s1_can_s;
  assign s1_load_s    = in_fire_s || scan_inj_s;
  assign eval_vec_s   = (state_r == ST_SCAN) ? cnt_r[N_IN-1:0] : inp;

  genvar g;
  generate
    for (g = 0; g < N_TERMS; g++) begin : g_term
      sop_term_match #(.N_IN(N_IN)) u_term (
        .mask (mask_r[g]),
        .val  (val_r[g]),
        .en   (en_r[g]),
        .inp  (eval_vec_s),
        .hit  (hit_s[g])
      );
    end
  endgenerate

  // Next-state logic for the idle/scan/drain controller.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (scan_go_s) state_s = ST_SCAN;
        else           state_s = ST_IDLE;
      end
      ST_SCAN: begin
        if (scan_inj_s && (cnt_r == LAST_VEC)) state_s = ST_DRAIN;
        else                                   state_s = ST_SCAN;
      end
      ST_DRAIN: begin
        if (pipe_empty_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Controller state, post-reset enable and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      live_r      <= 1'b0;
      scan_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      live_r      <= 1'b1;
      scan_done_r <= done_s;
    end
  end

  // Scan vector counter; one extra bit so the terminal count cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (scan_go_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (scan_inj_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Term table; out-of-range indices are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TERMS; k++) begin
        mask_r[k] <= {N_IN{1'b0}};
        val_r[k]  <= {N_IN{1'b0}};
      end
      en_r <= {N_TERMS{1'b0}};
    end else begin
      for (int k = 0; k < N_TERMS; k++) begin
        if (cfg_fire_s && (int'(cfg_idx) == k)) begin
          mask_r[k] <= cfg_mask;
          val_r[k]  <= cfg_val;
          en_r[k]   <= cfg_en;
        end
      end
    end
  end

  // Stage 1: capture the per-term hit vector and its origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_scan_r  <= 1'b0;
      s1_hit_r   <= {N_TERMS{1'b0}};
      s1_vec_r   <= {N_IN{1'b0}};
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_scan_r  <= scan_inj_s;
      s1_hit_r   <= hit_s;
      s1_vec_r   <= eval_vec_s;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: OR-reduce into the result; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_scan_r  <= 1'b0;
      s2_out_r   <= 1'b0;
      s2_hit_r   <= {N_TERMS{1'b0}};
      s2_vec_r   <= {N_IN{1'b0}};
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_scan_r  <= s1_scan_r;
      s2_out_r   <= |s1_hit_r;
      s2_hit_r   <= s1_hit_r;
      s2_vec_r   <= s1_vec_r;
    end else if (s2_xfer_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  // Scan results retire into the truth table instead of the result port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_r <= {TW{1'b0}};
    end else if (s2_valid_r && s2_scan_r) begin
      tt_r[s2_vec_r] <= s2_out_r;
    end else begin
      tt_r <= tt_r;
    end
  end

  assign cfg_ready = cfg_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = s2_valid_r && !s2_scan_r;
  assign out       = s2_out_r;
  assign out_hit   = s2_hit_r;
  assign scan_busy = (state_r != ST_IDLE);
  assign scan_done = scan_done_r;
  assign tt        = tt_r;

endmodule

// File: tb/tb_sop_eval.sv
// Self-checking bench for sop_eval: directed steps with randomized data,
// checked against a behavioural term-table model and a result queue.
module tb_sop_eval;

  localparam int NI = 4;
  localparam int NT = 8;
  localparam int IW = 3;
  localparam int TW = 16;

  typedef struct packed {
    logic          o;
    logic [NT-1:0] h;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid, cfg_ready, cfg_en;
  logic [IW-1:0] cfg_idx;
  logic [NI-1:0] cfg_mask, cfg_val;
  logic          in_valid, in_ready;
  logic [NI-1:0] inp;
  logic          out_valid, out_ready, out;
  logic [NT-1:0] out_hit;
  logic          scan_start, scan_busy, scan_done;
  logic [TW-1:0] tt;

  int errors = 0;
  int checks = 0;
  int delivered = 0;
  bit last_cfg_acc, last_in_acc;
  bit hold_pend = 1'b0;
  logic          hold_out;
  logic [NT-1:0] hold_hit;

  logic [NI-1:0] m_mask [NT];
  logic [NI-1:0] m_val  [NT];
  bit            m_en   [NT];
  res_t          exp_q [$];

  always #5 clk = ~clk;

  sop_eval #(.N_IN(NI), .N_TERMS(NT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_mask(cfg_mask), .cfg_val(cfg_val), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_hit(out_hit),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done), .tt(tt)
  );

  // Function value from the term list: a term matches when every cared bit
  // of the vector equals its literal.
  function automatic res_t model(input logic [NI-1:0] v);
    res_t r;
    r.h = '0;
    for (int k = 0; k < NT; k++)
      if (m_en[k] && ((v & m_mask[k]) == (m_val[k] & m_mask[k]))) r.h[k] = 1'b1;
    r.o = (r.h != '0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NT; k++) begin
      m_mask[k] = '0; m_val[k] = '0; m_en[k] = 1'b0;
    end
    exp_q.delete();
    hold_pend = 1'b0;
  endtask

  // One clock cycle: observe handshakes before the edge, update the model.
  task automatic tick();
    res_t r;
    #1;
    if (hold_pend) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_out", out, hold_out);
      check("hold_hit", out_hit, hold_hit);
    end
    hold_pend = out_valid && !out_ready;
    hold_out  = out;
    hold_hit  = out_hit;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1'b1, 1'b0);
      end else begin
        r = exp_q.pop_front();
        check("out", out, r.o);
        check("out_hit", out_hit, r.h);
        delivered++;
      end
    end
    last_in_acc  = in_valid && in_ready;
    last_cfg_acc = cfg_valid && cfg_ready;
    if (last_in_acc) exp_q.push_back(model(inp));
    if (last_cfg_acc) begin
      m_mask[cfg_idx] = cfg_mask;
      m_val[cfg_idx]  = cfg_val;
      m_en[cfg_idx]   = cfg_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_term(input int idx, input logic [NI-1:0] mk,
                            input logic [NI-1:0] vl, input logic en);
    bit done = 1'b0;
    cfg_idx = IW'(idx); cfg_mask = mk; cfg_val = vl; cfg_en = en;
    cfg_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      done = last_cfg_acc;
    end
    cfg_valid = 1'b0;
    if (!done) check("cfg_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int nxt, cyc, ov, sd, bz;
    logic [TW-1:0] exp_tt;
    res_t r;

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_mask = '0; cfg_val = '0;
    cfg_en = 1'b0; in_valid = 1'b0; inp = '0; out_ready = 1'b0; scan_start = 1'b0;
    clear_model();

    // Reset values.
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 1'b0);
    check("rst_out_hit", out_hit, '0);
    check("rst_scan_busy", scan_busy, 1'b0);
    check("rst_scan_done", scan_done, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_tt", tt, '0);
    #10 rst_n = 1'b1;
    #1;
    check("rel_cfg_ready_pre", cfg_ready, 1'b0);
    @(posedge clk); #1;
    check("rel_cfg_ready", cfg_ready, 1'b1);
    check("rel_in_ready", in_ready, 1'b1);

    // Single term, fixed two-cycle latency.
    write_term(0, 4'b1111, 4'b1111, 1'b1);
    inp = 4'b1111; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    check("lat_accept", last_in_acc, 1'b1);
    in_valid = 1'b0;
    check("lat_c1", out_valid, 1'b0);
    tick();
    check("lat_c2", out_valid, 1'b1);
    check("lat_out", out, 1'b1);
    check("lat_hit", out_hit, 8'h01);
    drain();

    // Term write and evaluation in the same cycle: write wins.
    cfg_idx = 3'd1; cfg_mask = 4'b1111; cfg_val = 4'b0000; cfg_en = 1'b1;
    cfg_valid = 1'b1; inp = 4'b0000; in_valid = 1'b1;
    #1;
    check("coll_cfg_ready", cfg_ready, 1'b1);
    check("coll_in_ready", in_ready, 1'b0);
    tick();
    check("coll_cfg_acc", last_cfg_acc, 1'b1);
    cfg_valid = 1'b0;
    tick();
    check("coll_in_acc", last_in_acc, 1'b1);
    r = model(4'b0000);
    check("coll_model_hit", r.h, 8'h02);
    drain();

    // Scan with two terms.
    write_term(0, 4'b0110, 4'b0000, 1'b1);
    write_term(1, 4'b1101, 4'b0001, 1'b1);
    for (int v = 0; v < TW; v++) begin
      r = model(v[NI-1:0]);
      exp_tt[v] = r.o;
    end
    check("scan_expected_tt", exp_tt, 16'h030B);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check("scan_busy_on", scan_busy, 1'b1);
    ov = 0; sd = 0; bz = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready && scan_busy) bz++;
      tick();
      if (out_valid) ov++;
      if (scan_done) begin
        sd++;
        check("scan_tt_at_done", tt, exp_tt);
      end
    end
    check("scan_done_pulses", sd, 1);
    check("scan_no_out_valid", ov, 0);
    check("scan_in_ready_busy", bz, 0);
    check("scan_busy_off", scan_busy, 1'b0);
    check("scan_tt", tt, exp_tt);

    // Back-to-back evaluations 0..15 with out_ready toggling.
    for (int k = 0; k < NT; k++)
      write_term(k, NI'($urandom), NI'($urandom), 1'($urandom_range(0, 1)));
    delivered = 0; nxt = 0; cyc = 0;
    in_valid = 1'b1;
    while (nxt < 16 && cyc < 200) begin
      inp = nxt[NI-1:0];
      out_ready = ~cyc[0];
      tick();
      if (last_in_acc) nxt++;
      cyc++;
    end
    check("b2b_accepted", nxt, 16);
    drain();
    check("b2b_delivered", delivered, 16);

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      inp       = NI'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Reset in the middle of a scan (vector 7).
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_scan_busy", scan_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    clear_model();
    check("abort_scan_busy", scan_busy, 1'b0);
    check("abort_tt", tt, '0);
    check("abort_scan_done", scan_done, 1'b0);
    check("abort_cfg_ready", cfg_ready, 1'b0);
    #10 rst_n = 1'b1;
    sd = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (scan_done) sd++;
    end
    check("abort_no_done", sd, 0);
    inp = NI'($urandom); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_out", out, 1'b0);
    check("post_rst_hit", out_hit, '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
